rename_stage: RTL
=================

Name: rename_stage

Overview:
- Single-issue register rename stage that maps 32 architectural registers onto 128 physical registers (pregs) through a speculative RAT.
- Sits directly downstream of the free preg queue: pops a free preg per destination-writing instruction, and pushes pregs back to it on commit or squash.
- Keeps a retirement RAT (RRAT) that restores the speculative RAT on flush.
- Output is a one-entry valid/ready register slice toward dispatch/ROB.

Parameters:
- NUM_AREG, 32, architectural registers; arch index width is $clog2(NUM_AREG).
- NUM_PREG, 128, physical registers; preg width PW = $clog2(NUM_PREG) = 7.
- PAYLOAD_W, 32, opaque per-instruction payload carried alongside the rename.

Ports:
- clk in 1: clock.
- rst_n in 1: synchronous, active-high reset (despite its name).
- in_valid in 1: decode offers an instruction.
- in_ready out 1: the stage accepts the offered instruction.
- in_rs1 in 5; in_rs2 in 5; in_rd in 5: architectural sources and destination.
- in_rd_wr in 1: instruction writes rd.
- in_payload in PAYLOAD_W: passed through unchanged.
- free_empty in 1: free queue empty.
- free_preg in PW: head of the free queue.
- free_r_en out 1: pop the free queue.
- free_w_en out 1: push to the free queue.
- free_preg_ret out PW: preg being pushed.
- out_valid out 1; out_ready in 1: downstream handshake.
- out_ps1 out PW; out_ps2 out PW; out_pd out PW; out_pd_old out PW: renamed sources, new destination, previous mapping of rd.
- out_rd out 5; out_rd_wr out 1; out_payload out PAYLOAD_W: passthrough.
- ret_en in 1: ROB retires or squashes one entry.
- ret_squash in 1: 0 = commit, 1 = squash.
- ret_arch in 5; ret_new_preg in PW; ret_old_preg in PW: the entry's rename record.
- flush in 1: pipeline flush.

Behaviour:
- need_alloc = in_rd_wr & (in_rd != 0). x0 is never renamed and always maps to preg 0.
- in_ready = (!out_valid | out_ready) & !(need_alloc & free_empty) & !flush. This depends combinationally on in_rd/in_rd_wr, which is permitted.
- accept = in_valid & in_ready. free_r_en = accept & need_alloc; the free_preg head is consumed in the same cycle.

On accept, the output registers load at the next edge (latency 1):
- out_ps1 = RAT[in_rs1] and out_ps2 = RAT[in_rs2], read before this instruction's own RAT write, so rd==rs1 yields the old mapping.
- out_pd = free_preg when need_alloc, else 0.
- out_pd_old = RAT[in_rd] when need_alloc, else 0.
- RAT[in_rd] <= free_preg when need_alloc.
- out_valid <= 1.
- If out_valid & out_ready and there is no accept: out_valid <= 0. Outputs hold stable while out_valid & !out_ready.

Return path (ret_en):
- Commit: RRAT[ret_arch] <= ret_new_preg; push ret_old_preg. Arch 0 and preg 0 are never pushed.
- Squash: push ret_new_preg; RRAT is unchanged.
- The push is registered: free_w_en/free_preg_ret assert the cycle after ret_en. At most one return per cycle.

Flush:
- At the next edge, RAT <= RRAT. This includes a commit presented in the same cycle (bypassed), so RAT[ret_arch] = ret_new_preg.
- out_valid <= 0 and in_ready = 0 during the flush cycle.
- The return path keeps operating during flush; the ROB squashes its entries through ret.

Reset:
- RAT[i] = RRAT[i] = i for i in 0..31.
- out_valid=0, free_w_en=0, free_preg_ret=0, all out_* = 0.
- Free queue contents are owned by the free queue.
- Reset mid-operation discards the output slice and pending push.

Boundary conditions:
- free_empty with need_alloc: stall, in_ready = 0.
- free_empty with no destination (or rd = 0): the instruction proceeds.
- Same-cycle accept and commit to the same arch reg: the accept wins the RAT write; the commit writes only the RRAT.

Optional Feature:
- RENAME_STALL_CNT_EN defined:
  - Adds output stall_cnt (32 bits).
  - Increments each cycle with in_valid & !in_ready & need_alloc & free_empty.
  - Saturates at 0xFFFFFFFF; resets to 0.
- Undefined: the port and counter do not exist.

Test Plan:
- Reset, then in_rd=5 wr, rs1=5, free_preg=40 -> next cycle out_pd=40, out_pd_old=5, out_ps1=5; subsequent rs1=5 -> out_ps1=40.
- in_rd=0, in_rd_wr=1, free_empty=1 -> accepted, free_r_en=0, out_pd=0; same with in_rd=3 -> in_ready=0, stall_cnt increments each cycle.
- out_ready=0 for 3 cycles with in_valid held -> outputs stable, in_ready=0, no free_r_en; out_ready=1 -> the next instruction accepted back-to-back.
- Commit ret_arch=5, new=40, old=5 -> one cycle later free_w_en=1, free_preg_ret=5; squash new=41 -> free_preg_ret=41, RRAT unchanged.
- Rename x7->50, x7->51, commit x7 with new=50, then flush -> RAT[7]=50, out_valid=0; rs1=7 next -> out_ps1=50.
- Flush in the same cycle as a commit of x9 with new=60 -> RAT[9]=60 after the flush.

Source files
------------

// File: rtl/rename_stage.sv
// Single-issue register rename stage: speculative RAT, retirement RAT, free-queue interface
// and a one-entry output slice. Optional stall counter under RENAME_STALL_CNT_EN.
module rename_stage #(
  parameter int NUM_AREG  = 32,
  parameter int NUM_PREG  = 128,
  parameter int PAYLOAD_W = 32,
  localparam int AW = $clog2(NUM_AREG),
  localparam int PW = $clog2(NUM_PREG)
) (
`ifdef RENAME_STALL_CNT_EN
  output logic [31:0]          stall_cnt,
`endif
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_rs1,
  input  logic [AW-1:0]        in_rs2,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_rd_wr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 free_empty,
  input  logic [PW-1:0]        free_preg,
  output logic                 free_r_en,
  output logic                 free_w_en,
  output logic [PW-1:0]        free_preg_ret,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_ps1,
  output logic [PW-1:0]        out_ps2,
  output logic [PW-1:0]        out_pd,
  output logic [PW-1:0]        out_pd_old,
  output logic [AW-1:0]        out_rd,
  output logic                 out_rd_wr,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 ret_en,
  input  logic                 ret_squash,
  input  logic [AW-1:0]        ret_arch,
  input  logic [PW-1:0]        ret_new_preg,
  input  logic [PW-1:0]        ret_old_preg,
  input  logic                 flush
);

  logic [PW-1:0] rat  [NUM_AREG];
  logic [PW-1:0] rrat [NUM_AREG];

  logic          need_alloc;
  logic          accept;
  logic          commit;
  logic          push;
  logic [PW-1:0] push_preg;

  always_comb begin
    need_alloc = in_rd_wr & (in_rd != '0);
    in_ready   = (~out_valid | out_ready) & ~(need_alloc & free_empty) & ~flush;
    accept     = in_valid & in_ready;
    free_r_en  = accept & need_alloc;
    commit     = ret_en & ~ret_squash & (ret_arch != '0);
    push_preg  = ret_squash ? ret_new_preg : ret_old_preg;
    push       = ret_en & (ret_arch != '0) & (push_preg != '0);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < NUM_AREG; i++) begin
        rat[i]  <= PW'(i);
        rrat[i] <= PW'(i);
      end
      out_valid     <= 1'b0;
      out_ps1       <= '0;
      out_ps2       <= '0;
      out_pd        <= '0;
      out_pd_old    <= '0;
      out_rd        <= '0;
      out_rd_wr     <= 1'b0;
      out_payload   <= '0;
      free_w_en     <= 1'b0;
      free_preg_ret <= '0;
    end else begin
      // Flush restores from the RRAT with a same-cycle commit bypassed in;
      // accept cannot coincide with flush since in_ready is low then.
      if (flush) begin
        for (int unsigned i = 0; i < NUM_AREG; i++) rat[i] <= rrat[i];
        if (commit) rat[ret_arch] <= ret_new_preg;
      end else if (accept && need_alloc) begin
        rat[in_rd] <= free_preg;
      end

      if (commit) rrat[ret_arch] <= ret_new_preg;

      if (accept) begin
        out_valid   <= 1'b1;
        out_ps1     <= rat[in_rs1];
        out_ps2     <= rat[in_rs2];
        out_pd      <= need_alloc ? free_preg : '0;
        out_pd_old  <= need_alloc ? rat[in_rd] : '0;
        out_rd      <= in_rd;
        out_rd_wr   <= in_rd_wr;
        out_payload <= in_payload;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end

      free_w_en <= push;
      if (push) free_preg_ret <= push_preg;
    end
  end

`ifdef RENAME_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && need_alloc && free_empty && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
